// File: rtl/hdlc_serial_crc.sv
// hdlc_serial_crc: bit-serial CRC-16-CCITT (x^16+x^12+x^5+1) generator/checker, MSB-first,
// non-reflected. Used on both sides of the HDLC datapath:
//   - transmit: absorb payload bits, then read the FCS out by feeding SCRC back as SData
//     (feedback is then always zero, so the register simply shifts left and empties);
//   - receive: absorb payload plus complemented FCS, then SCRCValid flags the good residue.
//
// Ports:
//   Clk        in   clock, all state changes on the rising edge
//   Rstn       in   asynchronous active-low reset, loads INIT
//   En         in   bit strobe, SData absorbed on this edge
//   Clr        in   synchronous clear to INIT, overrides En
//   SData      in   serial data bit
//   PCRC       out  16-bit CRC register
//   SCRC       out  PCRC[15], combinational
//   SCRCValid  out  PCRC == RESIDUE, combinational
module hdlc_serial_crc #(
  parameter logic [15:0] INIT    = 16'hFFFF,
  parameter logic [15:0] RESIDUE = 16'h1D0F
) (
  input  logic        Clk,
  input  logic        Rstn,
  input  logic        En,
  input  logic        Clr,
  input  logic        SData,
  output logic [15:0] PCRC,
  output logic        SCRC,
  output logic        SCRCValid
);

  localparam logic [15:0] Poly = 16'h1021;

  logic        fb;
  logic [15:0] crcNext;

  always_comb begin
    fb      = SData ^ PCRC[15];
    crcNext = {PCRC[14:0], 1'b0} ^ (fb ? Poly : 16'h0000);
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      PCRC <= INIT;
    end else if (Clr) begin
      PCRC <= INIT;
    end else if (En) begin
      PCRC <= crcNext;
    end
  end

  assign SCRC      = PCRC[15];
  assign SCRCValid = (PCRC == RESIDUE);

endmodule

// File: tb/tb_hdlc_serial_crc.sv
// Scoreboard bench for hdlc_serial_crc. The reference model keeps the list of bits absorbed
// since the last clear and computes the register by polynomial long division of
// (INIT * x^n + M(x) * x^16) by the generator.
module tb_hdlc_serial_crc;

  logic        Clk;
  logic        Rstn;
  logic        En;
  logic        Clr;
  logic        SData;
  logic [15:0] PCRC;
  logic        SCRC;
  logic        SCRCValid;

  hdlc_serial_crc dut (
    .Clk       (Clk),
    .Rstn      (Rstn),
    .En        (En),
    .Clr       (Clr),
    .SData     (SData),
    .PCRC      (PCRC),
    .SCRC      (SCRC),
    .SCRCValid (SCRCValid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int nCmp = 0;
  int nErr = 0;

  bit          hist[$];          // bits absorbed since last clear/reset
  logic [17:0] expQ[$];          // {PCRC, SCRC, SCRCValid} expected after each stepped edge
  logic [7:0]  msg[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] modelCrc();
    int          n;
    bit          a[$];
    logic [16:0] gen;
    logic [15:0] iv;
    logic [15:0] r;
    gen = 17'h11021;
    iv  = 16'hFFFF;
    n   = hist.size();
    for (int i = 0; i < n; i++) a.push_back(hist[i]);
    for (int i = 0; i < 16; i++) a.push_back(1'b0);
    for (int i = 0; i < 16; i++) a[i] = a[i] ^ iv[15-i];
    for (int i = 0; i < n; i++) begin
      if (a[i]) begin
        for (int j = 0; j <= 16; j++) a[i+j] = a[i+j] ^ gen[16-j];
      end
    end
    for (int i = 0; i < 16; i++) r[15-i] = a[n+i];
    return r;
  endfunction

  // Monitor: every stepped edge has one expected entry.
  always @(posedge Clk) begin
    logic [17:0] e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("scoreboard", {14'd0, PCRC, SCRC, SCRCValid}, {14'd0, e});
    end
  end

  // One clock of stimulus; inputs return to idle after the edge.
  task automatic step(input bit en, input bit clr, input bit d);
    logic [15:0] r;
    @(negedge Clk);
    En = en; Clr = clr; SData = d;
    if (clr) hist.delete();
    else if (en) hist.push_back(d);
    r = modelCrc();
    expQ.push_back({r, r[15], r == 16'h1D0F});
    @(posedge Clk);
    #2;
    En = 1'b0; Clr = 1'b0; SData = 1'b0;
  endtask

  task automatic feedByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'($urandom));
      step(1'b1, 1'b0, b[i]);
    end
  endtask

  task automatic feedWord(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) step(1'b1, 1'b0, w[i]);
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] r;
    int          k;
    int          len;
    Rstn = 1'b1; En = 1'b0; Clr = 1'b0; SData = 1'b0;
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);

    // Asynchronous reset with no clock edge yet.
    #3 Rstn = 1'b0;
    #1;
    check("reset_pcrc", {16'd0, PCRC}, 32'h0000FFFF);
    check("reset_scrc", {31'd0, SCRC}, 32'd1);
    check("reset_valid", {31'd0, SCRCValid}, 32'd0);
    @(negedge Clk);
    Rstn = 1'b1;

    // Single bits from INIT.
    step(1'b1, 1'b0, 1'b0);
    check("bit0_from_init", {16'd0, PCRC}, 32'h0000EFDF);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("bit1_from_init", {16'd0, PCRC}, 32'h0000FFFE);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("hold_no_en", {16'd0, PCRC}, 32'h0000FFFF);

    // Check string with idle gaps, then complemented FCS.
    for (int i = 0; i < 9; i++) feedByte(msg[i]);
    check("check_string", {16'd0, PCRC}, 32'h000029B1);
    feedWord(16'hD64E);
    check("residue_pcrc", {16'd0, PCRC}, 32'h00001D0F);
    check("residue_valid", {31'd0, SCRCValid}, 32'd1);

    // Single corrupted data bit must break the residue.
    step(1'b0, 1'b1, 1'b0);
    k = $urandom_range(0, 71);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] b;
      b = msg[i];
      if (k / 8 == i) b[k % 8] = ~b[k % 8];
      feedByte(b);
    end
    feedWord(16'hD64E);
    check("corrupt_valid", {31'd0, SCRCValid}, 32'd0);

    // FCS readout: feed SCRC back; sequence must be 29B1 MSB-first.
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) feedByte(msg[i]);
    rd = 16'h29B1;
    for (int i = 0; i < 16; i++) begin
      check("readout_bit", {31'd0, SCRC}, {31'd0, rd[15-i]});
      step(1'b1, 1'b0, rd[15-i]);
    end
    check("readout_final", {16'd0, PCRC}, 32'h00000000);

    // Clr beats En mid-frame.
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'($urandom));
    step(1'b1, 1'b1, 1'b0);
    check("clr_priority", {16'd0, PCRC}, 32'h0000FFFF);

    // Async reset mid-frame.
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'($urandom));
    #1 Rstn = 1'b0;
    #1;
    check("async_reset_mid", {16'd0, PCRC}, 32'h0000FFFF);
    @(negedge Clk);
    Rstn = 1'b1;
    hist.delete();
    step(1'b1, 1'b0, 1'b0);
    check("resume_after_reset", {16'd0, PCRC}, 32'h0000EFDF);

    // Random frames with sparse En and occasional Clr, closed with model FCS.
    for (int f = 0; f < 6; f++) begin
      step(1'b0, 1'b1, 1'b0);
      len = $urandom_range(8, 60);
      for (int i = 0; i < len; i++) begin
        step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0), 1'($urandom));
      end
      r = ~modelCrc();
      feedWord(r);
      check("random_frame_valid", {31'd0, SCRCValid}, 32'd1);
    end

    repeat (2) @(posedge Clk);
    #3;
    check("scoreboard_drained", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/hdlc_serial_crc.md
Name: hdlc_serial_crc

Overview:
Bit-serial CRC-16-CCITT generator/checker (polynomial x^16+x^12+x^5+1, 0x1021, MSB-first non-reflected shift) for the HDLC datapath. The transmitter feeds it one bit per enabled cycle to build the FCS. It then streams the register out MSB-first by feeding PCRC[15] back as data, which shifts the register left with no polynomial injection. The receiver uses the same block and checks the good-frame residue after the complemented FCS has been absorbed.

Parameters:
INIT, 16'hFFFF, value loaded into the CRC register on reset and on Clr.
RESIDUE, 16'h1D0F, register value that indicates a correct frame, i.e. data followed by the complemented FCS sent MSB-first.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Rstn  input  1  asynchronous active-low reset.
En  input  1  bit strobe; when high, SData is absorbed this cycle.
Clr  input  1  synchronous clear to INIT.
SData  input  1  serial data bit.
PCRC  output  16  parallel CRC register, registered.
SCRC  output  1  serial CRC output, combinational, equal to PCRC[15].
SCRCValid  output  1  combinational; high when PCRC == RESIDUE.

Behaviour:
- One clock domain: Clk. Reset is asynchronous and active-low (Rstn). Rstn low forces PCRC = INIT immediately, with no clock edge needed.
- Reset-state outputs: PCRC = INIT, SCRC = INIT[15] (1 for the default), SCRCValid = (INIT == RESIDUE) (0 for the defaults).
- Register update per rising edge, highest priority first:
  - Clr = 1: PCRC <= INIT, regardless of En and SData.
  - Else En = 1: fb = SData ^ PCRC[15]; PCRC <= {PCRC[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0000).
  - Else: hold.
- Latency: one cycle. PCRC reflects the bit absorbed on the previous enabled edge.
- Clr and En asserted together: Clr wins; the bit is discarded.
- En may be held continuously or pulsed sparsely. Only enabled edges advance the register, with no cross-cycle state beyond PCRC.
- FCS output mode: feeding SData = PCRC[15] for 16 enabled cycles shifts the register out MSB-first (fb = 0). After those 16 cycles PCRC = 16'h0000.
  - The transmitter line-codes the complement of each bit (~SCRC).
- Check mode: after the data bits and then the 16 complemented FCS bits, MSB-first, PCRC == RESIDUE and SCRCValid = 1.
- SCRC and SCRCValid are purely combinational from PCRC, with no extra register stage.
- No width growth or saturation: 16-bit register, XOR arithmetic only.
- The block has no notion of bytes or bit order. The caller decides bit ordering within a byte.
- Reset mid-frame: PCRC returns to INIT asynchronously. Operation resumes on the first enabled edge after Rstn rises.

Test Plan:
- Reset: assert Rstn = 0 between clock edges -> PCRC = 16'hFFFF immediately, SCRC = 1, SCRCValid = 0.
- Single bits from INIT:
  - En = 1, SData = 0 -> PCRC = 16'hEFDF after one edge.
  - From INIT, En = 1, SData = 1 -> PCRC = 16'hFFFE.
  - With En = 0 -> PCRC stays 16'hFFFF.
- Check string: ASCII "123456789", each byte MSB-first, 72 enabled bits with idle En = 0 gaps interleaved -> PCRC = 16'h29B1.
- Residue: after 16'h29B1, feed ~16'h29B1 = 16'hD64E MSB-first -> PCRC = 16'h1D0F, SCRCValid = 1. Corrupt one data bit and repeat -> SCRCValid = 0.
- FCS readout: after 16'h29B1, feed SData = SCRC for 16 enabled cycles -> the SCRC sequence is 0010100110110001 and the final PCRC = 16'h0000.
- Clear priority: mid-frame, assert Clr = 1 with En = 1 and SData = 0 -> PCRC = 16'hFFFF on the next edge, not 16'hEFDF. Assert Rstn = 0 mid-frame -> PCRC = 16'hFFFF asynchronously.
